// File: rtl/dpram_frame_reader.sv
// Read-side engine for the sample DPRAM: streams a circular frame out through a
// credit-controlled skid FIFO that hides the RAM read latency.
module dpram_frame_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 11,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   frame_len,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_READ  | issuing RAM reads, gated by FIFO credit
    // ST_DRAIN | all reads issued, waiting for the last beat to handshake
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int CW    = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]      rd_left_q, rd_left_d;
    logic [LEN_W-1:0]      out_left_q, out_left_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [CW-1:0]         inflight_c;
    logic                  rd_en_c;
    logic                  push_c;
    logic                  pop_c;

    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight_c = inflight_c + CW'(pipe_q[i]);
        end
    end

    // Credit covers both stored samples and reads still in the RAM pipe.
    assign rd_en_c = (state_q == ST_READ) && (rd_left_q != '0) &&
                     ((count_q + inflight_c) < CW'(FIFO_DEPTH));
    assign push_c  = pipe_q[RD_LATENCY-1];
    assign pop_c   = m_valid && m_ready;

    assign m_valid   = (count_q != '0);
    assign m_data    = m_valid ? fifo_mem[rd_ptr_q] : '0;
    assign m_last    = m_valid && (out_left_q == LEN_W'(1));
    assign ram_addr  = rd_addr_q;
    assign ram_rd_en = rd_en_c;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = 1'b0;
        count_d    = count_q + CW'(push_c) - CW'(pop_c);

        pipe_d    = '0;
        pipe_d[0] = rd_en_c;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d   = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            out_left_d = out_left_q - LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (frame_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rd_addr_d  = start_addr;
                        rd_left_d  = frame_len;
                        out_left_d = frame_len;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rd_en_c) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_left_d = rd_left_q - LEN_W'(1);
                    if (rd_left_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_c && m_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops everything, including returns still in the RAM pipe.
        if (abort) begin
            state_d    = ST_IDLE;
            rd_left_d  = '0;
            out_left_d = '0;
            pipe_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            pipe_q     <= pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !abort && !rst) begin
            fifo_mem[wr_ptr_q] <= ram_rd_data;
        end
    end

endmodule

// File: doc/dpram_frame_reader.md
Name: dpram_frame_reader

Overview:
- Read-side engine for the 8192x11 sample DPRAM: drains a frame of stored samples through the RAM's read port and presents them as a valid/ready stream to downstream display/analysis logic.
- The capture logic writes the frame through the other port; this block reads it back.
- Handles the RAM's fixed read latency and circular (wrap-around) addressing.
- Absorbs downstream back-pressure with a small credit-controlled FIFO, sustaining 1 sample/cycle.

Parameters:
- ADDR_WIDTH, 13, RAM address width; frame buffer depth 2**ADDR_WIDTH.
- DATA_WIDTH, 11, sample width.
- RD_LATENCY, 1, RAM read latency in cycles: 1 with no output register, 2 with output register. Legal values 1..2.
- FIFO_DEPTH, RD_LATENCY+2, depth of the internal skid FIFO. Must be >= RD_LATENCY+1.

Ports:
- clk  in  1  Single clock; RAM read port on same clock.
- rst  in  1  Synchronous active-high reset.
- start  in  1  One-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  First RAM address of the frame.
- frame_len  in  ADDR_WIDTH+1  Sample count, 0..2**ADDR_WIDTH.
- abort  in  1  Synchronous cancel of the current frame.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_rd_en  out  1  Read strobe; one asserted cycle is one read.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after the strobe.
- m_data  out  DATA_WIDTH  Stream data.
- m_valid  out  1  Stream valid.
- m_ready  in  1  Stream ready.
- m_last  out  1  High with the final sample of the frame.
- busy  out  1  High in any state other than IDLE.
- done  out  1  One-cycle pulse when a frame completes normally.

Behaviour:
- Reset (rst=1 at posedge): state IDLE; FIFO and in-flight pipe flushed.
  - Outputs: m_valid=0, m_last=0, m_data=0, ram_rd_en=0, ram_addr=0, busy=0, done=0.
- States:
  - IDLE: start=1 -> if frame_len==0, pulse done next cycle and stay IDLE; otherwise load rd_addr=start_addr, rd_left=frame_len, out_left=frame_len, and go to READ.
  - READ: issue reads until rd_left==0, then go to DRAIN.
  - DRAIN: wait until the last beat handshakes (m_valid&m_ready&m_last), then go to IDLE with done=1 for one cycle.
- Read issue:
  - ram_rd_en=1 in a cycle iff state==READ, rd_left!=0, and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is the number of strobes issued whose data has not yet returned, tracked by a RD_LATENCY-deep valid shift pipe.
  - Each strobe: rd_addr increments modulo 2**ADDR_WIDTH (8191 -> 0) and rd_left decrements.
- Data return: ram_rd_data is written into the FIFO on the cycle the pipe's tail bit is set. The credit rule guarantees no overflow; an overflow must never occur.
- Output:
  - m_valid = FIFO not empty; m_data = FIFO head.
  - Pop on m_valid&m_ready; out_left decrements per pop.
  - m_last = m_valid && out_left==1.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
- Latency: start accepted at edge T -> first ram_rd_en in cycle T+1 -> first m_valid in cycle T+2+RD_LATENCY (T+3 at the default).
- Throughput: with m_ready held 1, one beat per cycle, no bubbles.
- start while busy: ignored, no effect.
- abort=1 (any state): next cycle IDLE, FIFO flushed, in-flight returns discarded, m_valid=0, no done pulse.
  - abort takes priority over start in the same cycle.
  - rst takes priority over abort.
- done and m_last never assert for an aborted or zero-length frame (the zero-length done pulse excepted).

Test Plan:
- Reset, then start_addr=0, frame_len=8192, m_ready=1, RAM preloaded with data=~addr[10:0] -> 8192 beats with m_data=0x7FF,0x7FE,… ; m_last on beat 8192; done one cycle later; first m_valid at T+3.
- start_addr=8190, frame_len=4 -> reads addresses 8190,8191,0,1 in order; m_last on the 4th beat.
- frame_len=64, m_ready toggled by pseudo-random 50% pattern -> exactly 64 beats in address order; no duplicates or losses; data stable while stalled; ram_rd_en never asserted with fifo_count+inflight==FIFO_DEPTH.
- frame_len=0 -> done pulse the cycle after start; m_valid and ram_rd_en stay 0; busy stays 0.
- abort mid-frame after 10 beats with reads in flight -> m_valid=0 next cycle; no further beats, no done; a new start then produces a correct full frame.
- start pulsed while busy, and rst asserted mid-frame -> second start ignored; on rst all outputs return to reset values next cycle.
